mul4_fitness_scorer: RTL

MUL4_FITNESS_SCORER -- requirements
Module: mul4_fitness_scorer

---
 rtl/mul4_eval_pkg.sv | 24 ++
 rtl/mul4_golden_lanes.sv | 31 +++
 rtl/mul4_fitness_scorer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared types, sizes and the popcount helper for the 2x2-bit multiplier fitness scorer.
package mul4_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_REPORT
    } state_e;

    localparam int unsigned LANES          = 16;
    localparam int unsigned BITS_PER_LANE  = 4;
    localparam int unsigned MAX_BEAT_SCORE = 64;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mul4_golden_lanes.sv
// Combinational reference: 16 independent 2-bit x 2-bit unsigned products, bit-sliced.
module mul4_golden_lanes
    import mul4_eval_pkg::*;
(
    input  logic [LANES-1:0] a1,
    input  logic [LANES-1:0] a0,
    input  logic [LANES-1:0] b1,
    input  logic [LANES-1:0] b0,
    output logic [LANES-1:0] g3,
    output logic [LANES-1:0] g2,
    output logic [LANES-1:0] g1,
    output logic [LANES-1:0] g0
);

    always_comb begin
        logic [3:0] p;
        g3 = '0;
        g2 = '0;
        g1 = '0;
        g0 = '0;
        p  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            p     = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
            g3[i] = p[3];
            g2[i] = p[2];
            g1[i] = p[1];
            g0[i] = p[0];
        end
    end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores candidate multiplier outputs against the golden product over a batch of beats;
// two-stage pipeline feeding saturating accumulators, result held until taken.
module mul4_fitness_scorer
    import mul4_eval_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned BEAT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [15:0]        a1,
    input  logic [15:0]        a0,
    input  logic [15:0]        b1,
    input  logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] lanes_ok,
    output logic [BEAT_W-1:0]  beats,
    output logic               perfect
);

    state_e             state_q;
    logic               drain_cnt_q;
    logic               out_valid_q;
    logic               s1_valid_q;
    logic [15:0]        s1_a1_q, s1_a0_q, s1_b1_q, s1_b0_q;
    logic [15:0]        s1_y3_q, s1_y2_q, s1_y1_q, s1_y0_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] lanes_q, lanes_d;
    logic [BEAT_W-1:0]  beats_q, beats_d;
    logic               perfect_q, perfect_d;

    logic [15:0]                    g3, g2, g1, g0;
    logic [LANES*BITS_PER_LANE-1:0] mismatch;
    logic [LANES-1:0]               lane_bad;
    logic [6:0]                     bit_match, lane_match;
    logic [SCORE_W:0]               score_sum, lanes_sum;
    logic                           accept;

    assign in_ready = !rst && (state_q == ST_IDLE || state_q == ST_ACCUM);
    assign accept   = in_valid && in_ready;

    mul4_golden_lanes u_golden (
        .a1(s1_a1_q), .a0(s1_a0_q), .b1(s1_b1_q), .b0(s1_b0_q),
        .g3(g3), .g2(g2), .g1(g1), .g0(g0)
    );

    assign mismatch   = {s1_y3_q ^ g3, s1_y2_q ^ g2, s1_y1_q ^ g1, s1_y0_q ^ g0};
    assign lane_bad   = mismatch[63:48] | mismatch[47:32] | mismatch[31:16] | mismatch[15:0];
    assign bit_match  = 7'(MAX_BEAT_SCORE) - popcount64(mismatch);
    assign lane_match = 7'(LANES) - popcount64(64'(lane_bad));
    assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(bit_match);
    assign lanes_sum  = {1'b0, lanes_q} + (SCORE_W+1)'(lane_match);

    always_comb begin
        score_d   = score_q;
        lanes_d   = lanes_q;
        beats_d   = beats_q;
        perfect_d = perfect_q;
        if (s1_valid_q) begin
            score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            lanes_d   = lanes_sum[SCORE_W] ? '1 : lanes_sum[SCORE_W-1:0];
            beats_d   = (beats_q == '1) ? beats_q : beats_q + 1'b1;
            // first beat seeds the flag, later beats can only clear it
            perfect_d = (bit_match == 7'(MAX_BEAT_SCORE)) && (beats_q == '0 || perfect_q);
        end
        if (state_q == ST_REPORT && out_ready) begin
            score_d   = '0;
            lanes_d   = '0;
            beats_d   = '0;
            perfect_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 1'b0;
            out_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            score_q     <= '0;
            lanes_q     <= '0;
            beats_q     <= '0;
            perfect_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a1_q <= a1;
                s1_a0_q <= a0;
                s1_b1_q <= b1;
                s1_b0_q <= b0;
                s1_y3_q <= y3;
                s1_y2_q <= y2;
                s1_y1_q <= y1;
                s1_y0_q <= y0;
            end
            score_q   <= score_d;
            lanes_q   <= lanes_d;
            beats_q   <= beats_d;
            perfect_q <= perfect_d;
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        state_q     <= in_last ? ST_DRAIN : ST_ACCUM;
                        drain_cnt_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q) begin
                        state_q     <= ST_REPORT;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign score     = score_q;
    assign lanes_ok  = lanes_q;
    assign beats     = beats_q;
    assign perfect   = perfect_q;

endmodule
